// File: rtl/ncca_pkg.sv
// Shared types and constants for the time-shared approximate 8x8 multiplier.
// Holds the FSM state encoding, per-quadrant shift amounts and default approximation levels.
package ncca_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LL,
        LH,
        HL,
        HH,
        DONE
    } state_t;

    localparam int SHIFT_LL = 0;
    localparam int SHIFT_LH = 4;
    localparam int SHIFT_HL = 4;
    localparam int SHIFT_HH = 8;

    localparam int DEF_LVL_HH = 2;
    localparam int DEF_LVL_HL = 2;
    localparam int DEF_LVL_LH = 3;
    localparam int DEF_LVL_LL = 4;

endpackage

// File: rtl/ap4x4_unit.sv
// Combinational 4x4 multiplier with selectable approximation level.
// Level L drops every partial-product bit whose column weight is below 2^L; level 0 is exact.
module ap4x4_unit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] lvl,
    output logic [7:0] prod
);

    logic [7:0] exact_prod;
    logic [7:0] approx_prod;
    logic [7:0] keep_mask;
    logic [7:0] row;

    assign exact_prod = 8'(x) * 8'(y);
    assign keep_mask  = 8'hFF << lvl;

    // Each row is one shifted partial product; masking the columns before summing
    // also discards the carries those columns would have produced.
    always_comb begin
        approx_prod = '0;
        row         = '0;
        for (int j = 0; j < 4; j++) begin
            row         = y[j] ? (8'(x) << j) : 8'h00;
            approx_prod = approx_prod + (row & keep_mask);
        end
    end

    assign prod = (lvl == 3'd0) ? exact_prod : approx_prod;

endmodule

// File: rtl/seq_ncca_mul8.sv
// Sequential 8x8 multiplier that reuses one approximate 4x4 unit for the four quadrant products.
// Valid/ready on both sides; zero operands bypass the quadrant sequence entirely.
module seq_ncca_mul8
    import ncca_pkg::*;
#(
    parameter int LVL_HH = DEF_LVL_HH,
    parameter int LVL_HL = DEF_LVL_HL,
    parameter int LVL_LH = DEF_LVL_LH,
    parameter int LVL_LL = DEF_LVL_LL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        exact,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod,
    output logic        busy
);

    localparam logic [2:0] LV_HH = 3'(LVL_HH);
    localparam logic [2:0] LV_HL = 3'(LVL_HL);
    localparam logic [2:0] LV_LH = 3'(LVL_LH);
    localparam logic [2:0] LV_LL = 3'(LVL_LL);

    state_t      state;
    state_t      state_next;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic        exact_q;
    logic [16:0] acc;
    logic        accept;
    logic        in_quadrant;

    logic [3:0]  unit_x;
    logic [3:0]  unit_y;
    logic [2:0]  unit_lvl;
    logic [7:0]  unit_prod;
    logic [3:0]  shift_amt;
    logic [16:0] pp_shifted;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign accept      = in_valid && in_ready;
    assign in_quadrant = (state == LL) || (state == LH) || (state == HL) || (state == HH);

    ap4x4_unit u_unit (
        .x    (unit_x),
        .y    (unit_y),
        .lvl  (unit_lvl),
        .prod (unit_prod)
    );

    assign pp_shifted = 17'(unit_prod) << shift_amt;

    // Sub-unit inputs stay at zero outside the quadrant states, so a bypassed
    // operation never exercises the multiplier.
    always_comb begin
        state_next = state;
        unit_x     = '0;
        unit_y     = '0;
        unit_lvl   = '0;
        shift_amt  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (a == 8'h00 || b == 8'h00) ? DONE : LL;
                end
            end
            LL: begin
                unit_x     = a_q[3:0];
                unit_y     = b_q[3:0];
                unit_lvl   = exact_q ? 3'd0 : LV_LL;
                shift_amt  = 4'(SHIFT_LL);
                state_next = LH;
            end
            LH: begin
                unit_x     = a_q[3:0];
                unit_y     = b_q[7:4];
                unit_lvl   = exact_q ? 3'd0 : LV_LH;
                shift_amt  = 4'(SHIFT_LH);
                state_next = HL;
            end
            HL: begin
                unit_x     = a_q[7:4];
                unit_y     = b_q[3:0];
                unit_lvl   = exact_q ? 3'd0 : LV_HL;
                shift_amt  = 4'(SHIFT_HL);
                state_next = HH;
            end
            HH: begin
                unit_x     = a_q[7:4];
                unit_y     = b_q[7:4];
                unit_lvl   = exact_q ? 3'd0 : LV_HH;
                shift_amt  = 4'(SHIFT_HH);
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            exact_q <= 1'b0;
            acc     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                exact_q <= exact;
                acc     <= '0;
            end else if (in_quadrant) begin
                acc <= acc + pp_shifted;
            end
        end
    end

    assign prod = acc[16] ? 16'hFFFF : acc[15:0];

endmodule
